// File: rtl/sdram_pattern_tester.sv
// sdram_pattern_tester
//   Request-side initiator for the SDRAM controller user interface. On
//   start it writes a deterministic 32-bit pattern over a contiguous word
//   range, reads the range back, compares each word and reports the result.
//   Only one transaction is outstanding at a time.
//
// Ports
//   CLOCK_50        in   user-side clock, all logic on posedge
//   rst             in   synchronous active-high reset
//   start           in   level-sampled in IDLE/DONE, launches a run
//   address         out  [23:0] word address to the controller
//   req_write       out  one-cycle write request pulse
//   req_read        out  one-cycle read request pulse
//   data_in         out  [31:0] write data to the controller
//   data_out        in   [31:0] read data from the controller
//   data_valid      in   read data valid (rising edge consumed)
//   write_complete  in   write done (rising edge consumed)
//   busy            out  high from the first request until DONE
//   done            out  high in DONE until the next start or rst
//   pass            out  valid with done: no mismatch and no timeout
//   err_count       out  [15:0] mismatch count, saturating
//   first_err_addr  out  [23:0] address of the first mismatch, 0 if none
//   timeout         out  sticky, a wait exceeded TIMEOUT cycles
module sdram_pattern_tester #(
  parameter logic [23:0] START_ADDR = 24'h001000,
  parameter int unsigned NUM_WORDS  = 256,
  parameter logic [31:0] SEED       = 32'hDEADBEEF,
  parameter logic [31:0] STEP       = 32'h01010101,
  parameter int unsigned TIMEOUT    = 1023
) (
  input  logic        CLOCK_50,
  input  logic        rst,
  input  logic        start,
  output logic [23:0] address,
  output logic        req_write,
  output logic        req_read,
  output logic [31:0] data_in,
  input  logic [31:0] data_out,
  input  logic        data_valid,
  input  logic        write_complete,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] err_count,
  output logic [23:0] first_err_addr,
  output logic        timeout
);

  localparam int              CNT_W    = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TO_CNT  = CNT_W'(TIMEOUT);
  localparam logic [23:0]     LAST_IDX = 24'(NUM_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_REQ  = 3'd1,
    S_WR_WAIT = 3'd2,
    S_RD_REQ  = 3'd3,
    S_RD_WAIT = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [23:0]      idx_q, idx_d;
  logic [31:0]      pat_q, pat_d;
  logic [CNT_W-1:0] wcnt_q, wcnt_d;
  logic             wc_prev_q, dv_prev_q;
  logic [23:0]      addr_q, addr_d;
  logic [31:0]      din_q, din_d;
  logic             req_w_q, req_w_d;
  logic             req_r_q, req_r_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [15:0]      err_q, err_d;
  logic [23:0]      fea_q, fea_d;
  logic             to_q, to_d;

  // Completion strobes are consumed only on a rising edge so that a level
  // held across a transaction boundary cannot complete the next one.
  logic        wc_rise, dv_rise, last_word, expired, mismatch;
  logic [15:0] err_inc;

  assign wc_rise   = write_complete & ~wc_prev_q;
  assign dv_rise   = data_valid & ~dv_prev_q;
  assign last_word = (idx_q == LAST_IDX);
  assign expired   = (wcnt_q == TO_CNT);
  assign mismatch  = (data_out != pat_q);
  assign err_inc   = (err_q == 16'hFFFF) ? err_q : err_q + 16'd1;

  // State register
  always_ff @(posedge CLOCK_50) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (start) state_d = S_WR_REQ;
      S_WR_REQ:       state_d = S_WR_WAIT;
      S_WR_WAIT: begin
        if (wc_rise)      state_d = last_word ? S_RD_REQ : S_WR_REQ;
        else if (expired) state_d = S_DONE;
      end
      S_RD_REQ:       state_d = S_RD_WAIT;
      S_RD_WAIT: begin
        if (dv_rise)      state_d = last_word ? S_DONE : S_RD_REQ;
        else if (expired) state_d = S_DONE;
      end
      default:        state_d = S_IDLE;
    endcase
  end

  // Output / datapath next-value logic. Outputs are registered, so the
  // request pulse appears in the cycle after the REQ state is entered.
  always_comb begin
    idx_d   = idx_q;
    pat_d   = pat_q;
    wcnt_d  = wcnt_q;
    addr_d  = addr_q;
    din_d   = din_q;
    req_w_d = 1'b0;
    req_r_d = 1'b0;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    err_d   = err_q;
    fea_d   = fea_q;
    to_d    = to_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          idx_d  = '0;
          pat_d  = SEED;
          busy_d = 1'b1;
          done_d = 1'b0;
          pass_d = 1'b0;
          err_d  = '0;
          fea_d  = '0;
          to_d   = 1'b0;
        end
      end
      S_WR_REQ: begin
        req_w_d = 1'b1;
        addr_d  = START_ADDR + idx_q;
        din_d   = pat_q;
        wcnt_d  = '0;
      end
      S_WR_WAIT: begin
        if (wc_rise) begin
          if (last_word) begin
            idx_d = '0;
            pat_d = SEED;
          end else begin
            idx_d = idx_q + 24'd1;
            pat_d = pat_q + STEP;
          end
        end else if (expired) begin
          to_d   = 1'b1;
          busy_d = 1'b0;
          done_d = 1'b1;
          pass_d = 1'b0;
        end else begin
          wcnt_d = wcnt_q + CNT_W'(1);
        end
      end
      S_RD_REQ: begin
        req_r_d = 1'b1;
        addr_d  = START_ADDR + idx_q;
        din_d   = '0;
        wcnt_d  = '0;
      end
      S_RD_WAIT: begin
        if (dv_rise) begin
          if (mismatch) begin
            err_d = err_inc;
            // err_q never returns to zero within a run, so it marks "first"
            if (err_q == 16'd0) fea_d = addr_q;
          end
          if (last_word) begin
            busy_d = 1'b0;
            done_d = 1'b1;
            pass_d = !mismatch && (err_q == 16'd0) && !to_q;
          end else begin
            idx_d = idx_q + 24'd1;
            pat_d = pat_q + STEP;
          end
        end else if (expired) begin
          to_d   = 1'b1;
          busy_d = 1'b0;
          done_d = 1'b1;
          pass_d = 1'b0;
        end else begin
          wcnt_d = wcnt_q + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      idx_q     <= '0;
      pat_q     <= '0;
      wcnt_q    <= '0;
      wc_prev_q <= 1'b0;
      dv_prev_q <= 1'b0;
      addr_q    <= '0;
      din_q     <= '0;
      req_w_q   <= 1'b0;
      req_r_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      err_q     <= '0;
      fea_q     <= '0;
      to_q      <= 1'b0;
    end else begin
      idx_q     <= idx_d;
      pat_q     <= pat_d;
      wcnt_q    <= wcnt_d;
      wc_prev_q <= write_complete;
      dv_prev_q <= data_valid;
      addr_q    <= addr_d;
      din_q     <= din_d;
      req_w_q   <= req_w_d;
      req_r_q   <= req_r_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      err_q     <= err_d;
      fea_q     <= fea_d;
      to_q      <= to_d;
    end
  end

  assign address        = addr_q;
  assign data_in        = din_q;
  assign req_write      = req_w_q;
  assign req_read       = req_r_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign first_err_addr = fea_q;
  assign timeout        = to_q;

endmodule

// File: doc/sdram_pattern_tester.md
Name: sdram_pattern_tester

Overview:
- Request-side initiator for the sdram_controller3 user interface; drives address/req_write/req_read/data_in and consumes write_complete/data_valid/data_out.
- On start: writes a deterministic 32-bit pattern over a contiguous word range, reads the range back, compares, and reports pass/fail, error count and first failing address.
- Sits in the CLOCK_50 domain beside the controller; used for board bring-up and as the self-checking stimulus source in simulation.

Parameters:
- START_ADDR, 24'h001000, first word address tested.
- NUM_WORDS, 256, words tested (1..2^24-START_ADDR).
- SEED, 32'hDEADBEEF, pattern for the first word.
- STEP, 32'h01010101, added to the pattern per word (mod 2^32).
- TIMEOUT, 1023, max CLOCK_50 cycles waited per transaction.

Ports:
- CLOCK_50  in  1  user-side clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  level-sampled in IDLE/DONE; launches a run.
- address  out  24  word address to the controller.
- req_write  out  1  one-cycle write request pulse.
- req_read  out  1  one-cycle read request pulse.
- data_in  out  32  write data to the controller.
- data_out  in  32  read data from the controller.
- data_valid  in  1  read data valid; rising edge consumed.
- write_complete  in  1  write done; rising edge consumed.
- busy  out  1  high from the first request until DONE.
- done  out  1  high in DONE until the next start or rst.
- pass  out  1  valid when done: err_count==0 and no timeout.
- err_count  out  16  mismatches, saturating at 16'hFFFF.
- first_err_addr  out  24  address of the first mismatch; 0 if none.
- timeout  out  1  sticky; set when any wait exceeds TIMEOUT.

Behaviour:
- Reset: state IDLE. All outputs 0, including address, data_in, req_*, busy, done, pass, err_count, first_err_addr and timeout. Edge-detect registers and counters are cleared.
- States: IDLE, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT, DONE.
- Run start: start=1 in IDLE or DONE at edge N. All results are cleared, idx=0, pat=SEED, busy=1, state WR_REQ. At edge N+1, req_write=1, address=START_ADDR+idx, data_in=pat.
- WR_REQ: req_write is high for exactly one cycle. State goes to WR_WAIT, and address and data_in are held stable until completion.
- WR_WAIT: wait for a rising edge of write_complete, using a registered previous value.
  - Then: if idx==NUM_WORDS-1, go to RD_REQ with idx=0 and pat=SEED. Otherwise idx+1, pat+STEP, go to WR_REQ.
- RD_REQ / RD_WAIT: the same pattern with req_read; data_in is not driven during reads.
- Compare: on a data_valid rising edge in RD_WAIT, data_out is compared with pat.
  - Mismatch: err_count is incremented (saturating). On the first mismatch only, first_err_addr is loaded with the current address.
  - Last word goes to DONE; otherwise the next read.
- Consecutive requests are at least 2 cycles apart (REQ then WAIT). No pipelining; one outstanding transaction at a time.
- Edges of write_complete or data_valid outside their WAIT state are ignored. This includes a data_valid edge during the write phase.
- A level held high across a transaction boundary does not re-trigger; a new rising edge is required.
- Timeout: a wait counter runs in each WAIT state and is cleared on entering it. On reaching TIMEOUT without the expected edge: timeout=1 and go to DONE. Remaining words are skipped.
- DONE: busy=0, done=1, pass=(err_count==0 && !timeout). Results hold until the next start or rst.
- start while busy (WR_*/RD_*) is ignored.
- Pattern and address arithmetic: 32-bit pattern wraps mod 2^32; address = START_ADDR + idx in 24-bit arithmetic.
- rst mid-run: at that edge req_* drop to 0, all outputs clear, state IDLE. A completion arriving afterwards is ignored.

Test Plan:
- NUM_WORDS=4 with an ideal responsive model:
  - Writes go to 0x1000..0x1003 with data DEADBEEF, DFAEBFF0, E0AFC0F1, E1B0C1F2.
  - Reads follow; done=1, pass=1, err_count=0, and each req pulse lasts exactly 1 cycle.
- Model corrupts the read at 0x1002 (returns 0) -> err_count=1, first_err_addr=0x001002, pass=0.
- Model corrupts every read, NUM_WORDS=4 -> err_count=4, first_err_addr=0x001000.
- Model never asserts write_complete, TIMEOUT=15:
  - Exactly one req_write is issued.
  - timeout=1 and done=1 sixteen cycles after the request; pass=0.
- Spurious data_valid pulse during the write phase, plus start pulsed while busy -> neither has any effect; run ends with pass=1.
- Apply rst 3 cycles into RD_WAIT, then start again -> outputs zero after reset, and the second run completes with pass=1 and err_count=0.
